// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the CSR access controller: funct3 codes, FSM states,
// write-kind encoding and CSR address field positions.
package csr_access_ctrl_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam int CSR_RO_HI = 11;
  localparam int CSR_RO_LO = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  typedef enum logic [1:0] {
    WR_NONE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_SET   = 2'd2,
    WR_CLEAR = 2'd3
  } csr_wr_kind_e;

  // Addresses with [11:10]==2'b11 are read-only by the privileged-spec convention.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[CSR_RO_HI:CSR_RO_LO] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_op_decode.sv
// Combinational decode of a CSR op: operand form, whether a read is issued,
// which write strobe applies, and whether funct3 names a CSR op at all.
module csr_op_decode
  import csr_access_ctrl_pkg::*;
#(
  parameter int SKIP_X0_READ = 1
) (
  input  logic [2:0]   i_funct3,
  input  logic [4:0]   i_rd,
  input  logic [4:0]   i_rs1,
  output logic         o_is_imm,
  output logic         o_do_read,
  output csr_wr_kind_e o_wr_kind,
  output logic         o_illegal_op
);

  always_comb begin
    o_is_imm     = i_funct3[2];
    o_do_read    = 1'b1;
    o_wr_kind    = WR_NONE;
    o_illegal_op = 1'b0;
    case (i_funct3)
      F3_CSRRW, F3_CSRRWI: begin
        o_wr_kind = WR_WRITE;
        // A swap into x0 has no use for the old value, so skip read side effects.
        if ((SKIP_X0_READ != 0) && (i_rd == 5'd0)) o_do_read = 1'b0;
      end
      F3_CSRRS, F3_CSRRSI: if (i_rs1 != 5'd0) o_wr_kind = WR_SET;
      F3_CSRRC, F3_CSRRCI: if (i_rs1 != 5'd0) o_wr_kind = WR_CLEAR;
      default: begin
        o_illegal_op = 1'b1;
        o_do_read    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Core-side CSR instruction sequencer: IDLE -> READ -> WRITE -> RESP.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; rsp_* is held while rsp_valid && !rsp_ready.
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SKIP_X0_READ = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_rs1_data,
  output logic            csr_read,
  output logic            csr_write,
  output logic            csr_set,
  output logic            csr_clear,
  output logic            csr_imm,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [4:0]      csr_uimm,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_exc_perm,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_rd_we,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_rd_data,
  output logic            rsp_illegal,
  output csr_state_e      dbg_state
);

  csr_state_e      r_state;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [XLEN-1:0] r_rdata;
  logic            r_perm;
  logic            r_req_ready;
  logic            r_csr_read, r_csr_write, r_csr_set, r_csr_clear, r_csr_imm;
  logic [11:0]     r_csr_addr;
  logic [XLEN-1:0] r_csr_wdata;
  logic [4:0]      r_csr_uimm;
  logic            r_rsp_valid, r_rsp_rd_we, r_rsp_illegal;
  logic [4:0]      r_rsp_rd;
  logic [XLEN-1:0] r_rsp_rd_data;

  logic [2:0]      w_dec_funct3;
  logic [4:0]      w_dec_rd;
  logic [4:0]      w_dec_rs1;
  logic            w_is_imm, w_do_read, w_illegal_op;
  csr_wr_kind_e    w_wr_kind;
  logic            w_ro_attempt;
  logic            w_wr_strobe;
  logic            w_illegal;

  // The read strobe is registered at the accept edge, so in IDLE the decoder
  // looks at the fields about to be latched.
  assign w_dec_funct3 = (r_state == ST_IDLE) ? req_funct3 : r_funct3;
  assign w_dec_rd     = (r_state == ST_IDLE) ? req_rd     : r_rd;
  assign w_dec_rs1    = (r_state == ST_IDLE) ? req_rs1    : r_rs1;

  csr_op_decode #(.SKIP_X0_READ(SKIP_X0_READ)) u_decode (
    .i_funct3     (w_dec_funct3),
    .i_rd         (w_dec_rd),
    .i_rs1        (w_dec_rs1),
    .o_is_imm     (w_is_imm),
    .o_do_read    (w_do_read),
    .o_wr_kind    (w_wr_kind),
    .o_illegal_op (w_illegal_op)
  );

  assign w_ro_attempt = (w_wr_kind != WR_NONE) && csr_is_ro(r_csr_addr);
  assign w_wr_strobe  = r_csr_write | r_csr_set | r_csr_clear;
  // A permission fault seen while the strobe is out means the CSR file drops the write.
  assign w_illegal    = w_illegal_op | r_perm | w_ro_attempt | (w_wr_strobe & csr_exc_perm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_funct3      <= '0;
      r_rd          <= '0;
      r_rs1         <= '0;
      r_rdata       <= '0;
      r_perm        <= 1'b0;
      r_req_ready   <= 1'b1;
      r_csr_read    <= 1'b0;
      r_csr_write   <= 1'b0;
      r_csr_set     <= 1'b0;
      r_csr_clear   <= 1'b0;
      r_csr_imm     <= 1'b0;
      r_csr_addr    <= '0;
      r_csr_wdata   <= '0;
      r_csr_uimm    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rd_we   <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_rd      <= '0;
      r_rsp_rd_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_funct3    <= req_funct3;
            r_rd        <= req_rd;
            r_rs1       <= req_rs1;
            r_req_ready <= 1'b0;
            r_csr_read  <= w_do_read;
            r_csr_imm   <= w_is_imm;
            r_csr_addr  <= req_csr;
            r_csr_wdata <= req_rs1_data;
            r_csr_uimm  <= req_rs1;
            r_state     <= ST_READ;
          end
        end
        ST_READ: begin
          r_csr_read  <= 1'b0;
          r_rdata     <= csr_rdata;
          r_perm      <= csr_exc_perm;
          if (!w_illegal_op && !csr_exc_perm && !w_ro_attempt) begin
            r_csr_write <= (w_wr_kind == WR_WRITE);
            r_csr_set   <= (w_wr_kind == WR_SET);
            r_csr_clear <= (w_wr_kind == WR_CLEAR);
          end
          r_state     <= ST_WRITE;
        end
        ST_WRITE: begin
          r_csr_write   <= 1'b0;
          r_csr_set     <= 1'b0;
          r_csr_clear   <= 1'b0;
          r_csr_imm     <= 1'b0;
          r_csr_addr    <= '0;
          r_csr_wdata   <= '0;
          r_csr_uimm    <= '0;
          r_rsp_valid   <= 1'b1;
          r_rsp_illegal <= w_illegal;
          r_rsp_rd_we   <= !w_illegal && (r_rd != 5'd0);
          r_rsp_rd      <= r_rd;
          r_rsp_rd_data <= (w_do_read && !w_illegal) ? r_rdata : '0;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rd_we   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_rsp_rd      <= '0;
            r_rsp_rd_data <= '0;
            r_req_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign csr_read    = r_csr_read;
  assign csr_write   = r_csr_write;
  assign csr_set     = r_csr_set;
  assign csr_clear   = r_csr_clear;
  assign csr_imm     = r_csr_imm;
  assign csr_addr    = r_csr_addr;
  assign csr_wdata   = r_csr_wdata;
  assign csr_uimm    = r_csr_uimm;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rd_we   = r_rsp_rd_we;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_rd_data = r_rsp_rd_data;
  assign rsp_illegal = r_rsp_illegal;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: one op per step, strobes and response
// checked cycle by cycle against hand-computed values.
module tb_csr_access_ctrl;
  import csr_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, req_rs1;
  logic [11:0] req_csr;
  logic [31:0] req_rs1_data;
  logic        csr_read, csr_write, csr_set, csr_clear, csr_imm;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_rdata;
  logic        csr_exc_perm;
  logic        rsp_valid, rsp_ready, rsp_rd_we, rsp_illegal;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_rd_data;
  csr_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_rd_p = 0, n_wr_p = 0, n_set_p = 0, n_clr_p = 0, n_multi = 0;

  csr_access_ctrl #(.XLEN(32), .SKIP_X0_READ(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_csr(req_csr), .req_rs1_data(req_rs1_data),
    .csr_read(csr_read), .csr_write(csr_write), .csr_set(csr_set), .csr_clear(csr_clear),
    .csr_imm(csr_imm), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_uimm(csr_uimm),
    .csr_rdata(csr_rdata), .csr_exc_perm(csr_exc_perm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_we(rsp_rd_we), .rsp_rd(rsp_rd),
    .rsp_rd_data(rsp_rd_data), .rsp_illegal(rsp_illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Strobe pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (csr_read)  n_rd_p++;
    if (csr_write) n_wr_p++;
    if (csr_set)   n_set_p++;
    if (csr_clear) n_clr_p++;
    if ((int'(csr_read) + int'(csr_write) + int'(csr_set) + int'(csr_clear)) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_rd_p = 0; n_wr_p = 0; n_set_p = 0; n_clr_p = 0;
  endtask

  // exp_kind: 0 none, 1 write, 2 set, 3 clear. hold = cycles rsp_ready stays low.
  task automatic run_op(input string t, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [11:0] csr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic perm_rd, input logic perm_wr,
                        input logic exp_rd, input int exp_kind, input logic exp_ill,
                        input logic exp_we, input logic [31:0] exp_data, input int hold);
    @(negedge clk);
    req_funct3 = f3; req_rd = rd; req_rs1 = rs1; req_csr = csr; req_rs1_data = wdata;
    csr_rdata = rdata; rsp_ready = (hold == 0); req_valid = 1'b1;
    check({t, " req_ready idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);                       // accept edge N
    #1 req_valid = 1'b0; csr_exc_perm = perm_rd; clear_counts();
    @(negedge clk);                       // READ
    check({t, " read strobe"}, 32'(csr_read), 32'(exp_rd));
    check({t, " addr"}, 32'(csr_addr), 32'(csr));
    check({t, " req_ready busy"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 csr_exc_perm = perm_wr;
    @(negedge clk);                       // WRITE
    check({t, " write strobe"}, 32'(csr_write), 32'(exp_kind == 1));
    check({t, " set strobe"}, 32'(csr_set), 32'(exp_kind == 2));
    check({t, " clear strobe"}, 32'(csr_clear), 32'(exp_kind == 3));
    check({t, " imm flag"}, 32'(csr_imm), 32'(f3[2]));
    check({t, " wdata"}, csr_wdata, wdata);
    check({t, " uimm"}, 32'(csr_uimm), 32'(rs1));
    check({t, " early rsp_valid"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);                       // edge N+2: response appears
    #1 csr_exc_perm = 1'b0;
    @(negedge clk);
    check({t, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({t, " rsp_illegal"}, 32'(rsp_illegal), 32'(exp_ill));
    check({t, " rsp_rd_we"}, 32'(rsp_rd_we), 32'(exp_we));
    check({t, " rsp_rd"}, 32'(rsp_rd), 32'(rd));
    check({t, " rsp_rd_data"}, rsp_rd_data, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({t, " held rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({t, " held rd_data"}, rsp_rd_data, exp_data);
      check({t, " held req_ready"}, 32'(req_ready), 32'd0);
      if (i == hold - 1) rsp_ready = 1'b1;
    end
    @(posedge clk);                       // response handshake
    #1;
    check({t, " back to idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check({t, " rsp dropped"}, 32'(rsp_valid), 32'd0);
    check({t, " read count"}, 32'(n_rd_p), 32'(exp_rd));
    check({t, " wr count"}, 32'(n_wr_p + n_set_p + n_clr_p), 32'(exp_kind != 0));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rd = '0; req_rs1 = '0;
    req_csr = '0; req_rs1_data = '0; csr_rdata = '0; csr_exc_perm = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset strobes", 32'({csr_read, csr_write, csr_set, csr_clear}), 32'd0);
    check("reset addr", 32'(csr_addr), 32'd0);
    check("reset rd_data", rsp_rd_data, 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1 reset = 1'b0;

    // T1 CSRRW rd=5 -> read + write, old value returned
    run_op("T1", 3'b001, 5'd5, 5'd1, 12'h340, 32'hDEADBEEF, 32'h12345678, 0, 0,
           1, 1, 0, 1, 32'h12345678, 0);
    // T2 CSRRS rs1=0 on RO CSR: pure read, legal
    run_op("T2", 3'b010, 5'd3, 5'd0, 12'hF14, 32'h0, 32'h00000000, 0, 0,
           1, 0, 0, 1, 32'h0, 0);
    // CSRRS rs1!=0 -> set pulse
    run_op("SET", 3'b010, 5'd2, 5'd2, 12'h300, 32'h00000008, 32'h0000A5A5, 0, 0,
           1, 2, 0, 1, 32'h0000A5A5, 0);
    // T3 CSRRWI to read-only CSR -> illegal, no write
    run_op("T3", 3'b101, 5'd4, 5'd7, 12'hC00, 32'h0, 32'h00001111, 0, 0,
           1, 0, 1, 0, 32'h0, 0);
    // T4 funct3=100 -> no strobes, illegal
    run_op("T4", 3'b100, 5'd6, 5'd1, 12'h340, 32'h0, 32'h00002222, 0, 0,
           0, 0, 1, 0, 32'h0, 0);
    // T5 CSRRC with permission fault during READ
    run_op("T5", 3'b011, 5'd8, 5'd2, 12'h341, 32'h0000000F, 32'h00000055, 1, 0,
           1, 0, 1, 0, 32'h0, 0);
    // CSRRW rd=x0: no read pulse, write still issued, rd_data 0
    run_op("X0", 3'b001, 5'd0, 5'd9, 12'h305, 32'h80000000, 32'h33333333, 0, 0,
           0, 1, 0, 0, 32'h0, 0);
    // CSRRW with permission fault during WRITE: strobe out, result illegal
    run_op("PW", 3'b001, 5'd10, 5'd1, 12'h340, 32'h11110000, 32'h44444444, 0, 1,
           1, 1, 1, 0, 32'h0, 0);
    // CSRRSI uimm=0, rd=x0 on RO CSR: legal read, value still returned
    run_op("SI0", 3'b110, 5'd0, 5'd0, 12'hC01, 32'h0, 32'h0000CAFE, 0, 0,
           1, 0, 0, 0, 32'h0000CAFE, 0);
    // T6 CSRRCI uimm=3 with response backpressure for 5 cycles
    run_op("T6", 3'b111, 5'd9, 5'd3, 12'h344, 32'h0, 32'h000000FF, 0, 0,
           1, 3, 0, 1, 32'h000000FF, 5);

    // T6b reset asserted mid-WRITE abandons the op
    @(negedge clk);
    req_funct3 = 3'b111; req_rd = 5'd9; req_rs1 = 5'd3; req_csr = 12'h344; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("T6b clear before reset", 32'(csr_clear), 32'd1);
    reset = 1'b1;
    #1;
    check("T6b strobes in reset", 32'({csr_read, csr_write, csr_set, csr_clear}), 32'd0);
    check("T6b state in reset", 32'(dbg_state), 32'(ST_IDLE));
    check("T6b req_ready in reset", 32'(req_ready), 32'd1);
    @(posedge clk); #1 reset = 1'b0; clear_counts();
    repeat (4) @(posedge clk);
    #1;
    check("T6b no strobes after", 32'(n_rd_p + n_wr_p + n_set_p + n_clr_p), 32'd0);
    check("T6b no rsp after", 32'(rsp_valid), 32'd0);
    check("one-hot strobes", 32'(n_multi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
